fp_add_scheduler: RTL and testbench
===================================

// Module: fp_add_scheduler
// PURPOSE
//  Round-robin arbiter sharing one single-precision adder instance among N_REQ requesters.
//  Each requester presents an operand pair and holds req until granted.
//  The block latches the winner's operands, pulses the adder start, waits for adder valid,
//  then returns the sum with a one-hot res_valid to the owning requester.
//  Sits between accumulation/sensor-processing clients and the shared adder.
// PARAMETERS
//  N_REQ     4   number of requesters (2..8)
//  EXPONENT  8   exponent width, passed through to the adder
//  MANTISSA  23  mantissa width; W = EXPONENT+MANTISSA+1
//  TIMEOUT   15  WAIT-cycle limit, used only with FP_SCHED_TIMEOUT_EN (>=8)
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous reset, active-high
//  req          in   N_REQ      request per client, held until gnt
//  op_a         in   N_REQ*W    operand A, client i at [i*W +: W]
//  op_b         in   N_REQ*W    operand B, same packing
//  gnt          out  N_REQ      one-hot 1-cycle pulse: operands captured
//  res_valid    out  N_REQ      one-hot 1-cycle pulse: res_data belongs to client i
//  res_data     out  W          result, held until next res_valid
//  add_strt     out  1          1-cycle start pulse to adder
//  add_in1      out  W          latched operand A to adder (held stable through WAIT)
//  add_in2      out  W          latched operand B to adder
//  add_busy     in   1          adder busy
//  add_valid    in   1          adder result valid (1-cycle pulse)
//  add_out      in   W          adder result
//  timeout_err  out  1          1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset: state=IDLE; gnt, res_valid, add_strt, timeout_err = 0; res_data, add_in1, add_in2 = 0;
//    owner=0; last=N_REQ-1; wdog=0.
//  All outputs are registered.
//  FSM has two states: IDLE and WAIT.
//  IDLE: when |req && !add_busy at a clock edge:
//   - winner = first asserted req scanning last+1, last+2, ... mod N_REQ
//   - latch op_a/op_b[winner] into add_in1/add_in2
//   - set gnt[winner]=1, add_strt=1, owner=winner, wdog=0
//   - go to WAIT
//   Otherwise stay in IDLE with all pulses 0.
//  WAIT:
//   - gnt and add_strt are cleared on the first WAIT edge (exactly 1 cycle high)
//   - on add_valid=1: res_data<=add_out, res_valid[owner]<=1, last<=owner, go to IDLE
//   - res_valid therefore rises 1 cycle after add_valid; with the 4-cycle adder, gnt->res_valid = 5 cycles
//   - a new grant is possible on the edge after returning to IDLE; res_valid and gnt never overlap
//  Client rules:
//   - a client may drop req the cycle after its gnt
//   - a still-high req is treated as a new operation
//   - req/op changes while not granted are legal; only the value at the grant edge is used
//  add_valid seen in IDLE is ignored; no result is produced.
//  Only one operation is outstanding; while in WAIT, req is not sampled.
//  N_REQ=1 degenerates to a start/wait sequencer with the same timing.
//  rst mid-operation aborts the operation with no res_valid; the adder shares rst, so both restart clean.
// CONFIGURATION
//  FP_SCHED_TIMEOUT_EN defined:
//   - wdog counts WAIT cycles
//   - if wdog reaches TIMEOUT without add_valid: res_data<=qNaN (sign 0, exponent all-ones,
//     mantissa MSB 1, i.e. 32'h7FC00000 at defaults), res_valid[owner]<=1, timeout_err<=1 for
//     1 cycle, last<=owner, go to IDLE
//   - add_valid on the same edge as expiry wins (normal result, no error)
//  FP_SCHED_TIMEOUT_EN undefined: no watchdog, WAIT waits forever; timeout_err is tied to 0.
// TESTING
//  T1 single op: req[2], a=3F800000, b=40000000 -> gnt[2] 1 cycle; add_strt 1 cycle;
//     res_valid[2] 5 cycles after gnt; res_data=40400000
//  T2 fairness: after reset hold req=4'b1111 with distinct ops -> grant order 0,1,2,3,0;
//     each res_valid targets the matching client
//  T3 back-to-back: req[1] held high, a=b=3FC00000 -> repeated grants to 1 only, each result 40400000;
//     gnt and res_valid never in the same cycle
//  T4 busy gating: force add_busy=1 with req[0]=1 -> no gnt and no add_strt until add_busy drops
//  T5 reset mid-WAIT: assert rst 2 cycles after gnt -> all outputs 0 immediately, no res_valid;
//     next req is served from client 0 first
//  T6 (FP_SCHED_TIMEOUT_EN) stub adder never raises add_valid -> after 15 WAIT cycles
//     res_valid[owner]=1, res_data=7FC00000, timeout_err 1-cycle pulse

Source files
------------

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one floating-point adder among N_REQ requesters.
// Optional watchdog on the adder wait enabled by defining FP_SCHED_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | no operation outstanding; arbitrate among req when adder is not busy
// S_WAIT | operands issued to adder; waiting for add_valid (or watchdog expiry)
module fp_add_scheduler #(
   parameter int N_REQ    = 4,
   parameter int EXPONENT = 8,
   parameter int MANTISSA = 23,
   parameter int TIMEOUT  = 15,
   localparam int W       = EXPONENT + MANTISSA + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] op_a,
   input  logic [N_REQ*W-1:0] op_b,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   res_valid,
   output logic [W-1:0]       res_data,
   output logic               add_strt,
   output logic [W-1:0]       add_in1,
   output logic [W-1:0]       add_in2,
   input  logic               add_busy,
   input  logic               add_valid,
   input  logic [W-1:0]       add_out,
   output logic               timeout_err
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state;
   logic [IW-1:0] owner;
   logic [IW-1:0] last;
   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] cand;

   // Scan starts just after the last served client so every requester gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IW'((int'(last) + k) % N_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

`ifdef FP_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
   logic [WD_W-1:0] wdog;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         gnt       <= '0;
         res_valid <= '0;
         add_strt  <= 1'b0;
         res_data  <= '0;
         add_in1   <= '0;
         add_in2   <= '0;
         owner     <= '0;
         last      <= IW'(N_REQ - 1);
`ifdef FP_SCHED_TIMEOUT_EN
         wdog        <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         gnt       <= '0;
         res_valid <= '0;
         add_strt  <= 1'b0;
`ifdef FP_SCHED_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (win_found && !add_busy) begin
                  add_in1  <= op_a[win_idx*W +: W];
                  add_in2  <= op_b[win_idx*W +: W];
                  gnt      <= N_REQ'(1) << win_idx;
                  add_strt <= 1'b1;
                  owner    <= win_idx;
                  state    <= S_WAIT;
`ifdef FP_SCHED_TIMEOUT_EN
                  wdog     <= '0;
`endif
               end
            end
            S_WAIT: begin
               // A real result on the expiry edge takes priority over the watchdog.
               if (add_valid) begin
                  res_data  <= add_out;
                  res_valid <= N_REQ'(1) << owner;
                  last      <= owner;
                  state     <= S_IDLE;
               end
`ifdef FP_SCHED_TIMEOUT_EN
               else if (wdog == WD_W'(TIMEOUT - 1)) begin
                  res_data    <= QNAN;
                  res_valid   <= N_REQ'(1) << owner;
                  timeout_err <= 1'b1;
                  last        <= owner;
                  state       <= S_IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: stub 4-cycle adder plus round-robin reference model.
module tb_fp_add_scheduler;
   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] op_a, op_b;
   logic [N-1:0]   gnt, res_valid;
   logic [W-1:0]   res_data, add_in1, add_in2, add_out;
   logic           add_strt, add_busy, add_valid, timeout_err;

   logic           force_busy = 1'b0;
   logic           inj_valid  = 1'b0;
   logic           adder_dead = 1'b0;
   int             adder_cnt;
   logic           mdl_valid;
   logic [W-1:0]   mdl_out;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_last;

   fp_add_scheduler #(.N_REQ(N), .EXPONENT(8), .MANTISSA(23), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
      .gnt(gnt), .res_valid(res_valid), .res_data(res_data),
      .add_strt(add_strt), .add_in1(add_in1), .add_in2(add_in2),
      .add_busy(add_busy), .add_valid(add_valid), .add_out(add_out),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Stub adder: known float sums for the directed cases, integer mix otherwise.
   function automatic logic [W-1:0] adder_fn(input logic [W-1:0] a, input logic [W-1:0] b);
      if ((a == 32'h3F800000 && b == 32'h40000000) || (a == 32'h40000000 && b == 32'h3F800000))
         return 32'h40400000;
      if (a == 32'h3FC00000 && b == 32'h3FC00000)
         return 32'h40400000;
      return a + (b ^ 32'h5A5A0000);
   endfunction

   // Next winner by the round-robin rule: first requester after the last served one.
   function automatic int rr_pick(input logic [N-1:0] r, input int lst);
      for (int k = 1; k <= N; k++) begin
         if (r[(lst + k) % N]) return (lst + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         adder_cnt <= 0;
         mdl_valid <= 1'b0;
         mdl_out   <= '0;
      end else begin
         mdl_valid <= 1'b0;
         if (add_strt && !adder_dead) begin
            adder_cnt <= 3;
            mdl_out   <= adder_fn(add_in1, add_in2);
         end else if (adder_cnt > 0) begin
            adder_cnt <= adder_cnt - 1;
            if (adder_cnt == 1) mdl_valid <= 1'b1;
         end
      end
   end

   assign add_busy  = (adder_cnt != 0) | force_busy;
   assign add_valid = mdl_valid | inj_valid;
   assign add_out   = inj_valid ? 32'hDEADBEEF : mdl_out;

   task automatic wait_gnt(input int limit, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (gnt == '0 && cyc < limit);
   endtask

   task automatic wait_res(input int limit, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (res_valid == '0 && cyc < limit);
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b expected 0", gnt); end
      n_checks++; if (res_valid !== '0) begin n_fail++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
      n_checks++; if (add_strt !== 1'b0) begin n_fail++; $display("FAIL rst_add_strt: got %b expected 0", add_strt); end
      n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL rst_res_data: got %h expected 0", res_data); end
      n_checks++; if (add_in1 !== '0 || add_in2 !== '0) begin n_fail++; $display("FAIL rst_add_in: got %h/%h expected 0", add_in1, add_in2); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
      rst = 1'b0;
      exp_last = N - 1;
   endtask

   task automatic test_single();
      int c, c2;
      op_a = '0; op_b = '0;
      op_a[2*W +: W] = 32'h3F800000;
      op_b[2*W +: W] = 32'h40000000;
      req = 4'b0100;
      wait_gnt(20, c);
      n_checks++; if (c !== 1 || gnt !== 4'b0100) begin n_fail++; $display("FAIL t1_gnt: got %b after %0d cycles expected 0100 after 1", gnt, c); end
      n_checks++; if (add_strt !== 1'b1) begin n_fail++; $display("FAIL t1_add_strt: got %b expected 1", add_strt); end
      n_checks++; if (add_in1 !== 32'h3F800000 || add_in2 !== 32'h40000000) begin n_fail++; $display("FAIL t1_operands: got %h/%h expected 3f800000/40000000", add_in1, add_in2); end
      req = '0;
      @(negedge clk);
      n_checks++; if (gnt !== '0 || add_strt !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_width: gnt %b add_strt %b expected 0/0", gnt, add_strt); end
      wait_res(30, c2);
      n_checks++; if (c2 + 1 !== 5) begin n_fail++; $display("FAIL t1_latency: got %0d expected 5", c2 + 1); end
      n_checks++; if (res_valid !== 4'b0100 || res_data !== 32'h40400000) begin n_fail++; $display("FAIL t1_result: got %b/%h expected 0100/40400000", res_valid, res_data); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL t1_timeout_err: got %b expected 0", timeout_err); end
      @(negedge clk);
      n_checks++; if (res_valid !== '0 || res_data !== 32'h40400000) begin n_fail++; $display("FAIL t1_hold: got %b/%h expected 0000/40400000", res_valid, res_data); end
      exp_last = 2;
   endtask

   task automatic test_fairness();
      int c, c2, w;
      logic [W-1:0] ea, eb;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_last = N - 1;
      for (int i = 0; i < N; i++) begin
         op_a[i*W +: W] = $urandom;
         op_b[i*W +: W] = $urandom;
      end
      req = 4'b1111;
      for (int it = 0; it < 5; it++) begin
         w  = rr_pick(req, exp_last);
         ea = op_a[w*W +: W];
         eb = op_b[w*W +: W];
         wait_gnt(20, c);
         n_checks++; if (c !== 1 || gnt !== N'(1) << w) begin n_fail++; $display("FAIL t2_gnt%0d: got %b after %0d cycles expected client %0d after 1", it, gnt, c, w); end
         n_checks++; if (add_in1 !== ea || add_in2 !== eb) begin n_fail++; $display("FAIL t2_operands%0d: got %h/%h expected %h/%h", it, add_in1, add_in2, ea, eb); end
         wait_res(30, c2);
         n_checks++; if (c2 !== 5 || res_valid !== N'(1) << w || res_data !== adder_fn(ea, eb)) begin n_fail++; $display("FAIL t2_result%0d: got %b/%h at %0d expected client %0d/%h at 5", it, res_valid, res_data, c2, w, adder_fn(ea, eb)); end
         exp_last = w;
         for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = $urandom;
            op_b[i*W +: W] = $urandom;
         end
      end
      req = '0;
   endtask

   task automatic test_back_to_back();
      int ngrant = 0, nres = 0;
      op_a[1*W +: W] = 32'h3FC00000;
      op_b[1*W +: W] = 32'h3FC00000;
      req = 4'b0010;
      for (int i = 1; i <= 36; i++) begin
         @(negedge clk);
         n_checks++; if ((gnt & res_valid) !== '0) begin n_fail++; $display("FAIL t3_overlap: gnt %b res_valid %b in same cycle", gnt, res_valid); end
         if (gnt != '0) begin
            ngrant++;
            n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL t3_gnt: got %b expected 0010", gnt); end
         end
         if (res_valid != '0) begin
            nres++;
            n_checks++; if (res_valid !== 4'b0010 || res_data !== 32'h40400000) begin n_fail++; $display("FAIL t3_result: got %b/%h expected 0010/40400000", res_valid, res_data); end
         end
      end
      req = '0;
      n_checks++; if (ngrant !== 6 || nres !== 6) begin n_fail++; $display("FAIL t3_count: got %0d grants %0d results expected 6/6", ngrant, nres); end
      exp_last = 1;
   endtask

   task automatic test_busy();
      int c, c2;
      logic [W-1:0] ea, eb;
      ea = $urandom; eb = $urandom;
      op_a[0 +: W] = ea; op_b[0 +: W] = eb;
      force_busy = 1'b1;
      req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++; if (gnt !== '0 || add_strt !== 1'b0) begin n_fail++; $display("FAIL t4_gated: gnt %b add_strt %b expected 0/0 while busy", gnt, add_strt); end
      end
      force_busy = 1'b0;
      wait_gnt(20, c);
      n_checks++; if (c !== 1 || gnt !== 4'b0001 || add_in1 !== ea || add_in2 !== eb) begin n_fail++; $display("FAIL t4_release: got %b %h/%h after %0d expected 0001 %h/%h after 1", gnt, add_in1, add_in2, c, ea, eb); end
      req = '0;
      wait_res(30, c2);
      n_checks++; if (res_valid !== 4'b0001 || res_data !== adder_fn(ea, eb)) begin n_fail++; $display("FAIL t4_result: got %b/%h expected 0001/%h", res_valid, res_data, adder_fn(ea, eb)); end
      exp_last = 0;
   endtask

   task automatic test_spurious_valid();
      logic [W-1:0] held;
      held = res_data;
      @(negedge clk);
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (res_valid !== '0 || res_data !== held) begin n_fail++; $display("FAIL idle_valid: got %b/%h expected 0000/%h", res_valid, res_data, held); end
      end
   endtask

   task automatic test_random();
      int c, c2, w;
      logic [N-1:0] r;
      logic [W-1:0] ea, eb;
      for (int it = 0; it < 12; it++) begin
         r = N'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = $urandom;
            op_b[i*W +: W] = $urandom;
         end
         req = r;
         w  = rr_pick(r, exp_last);
         ea = op_a[w*W +: W];
         eb = op_b[w*W +: W];
         wait_gnt(20, c);
         n_checks++; if (gnt !== N'(1) << w || add_in1 !== ea || add_in2 !== eb) begin n_fail++; $display("FAIL rnd_gnt%0d: got %b %h/%h expected client %0d %h/%h (req %b)", it, gnt, add_in1, add_in2, w, ea, eb, r); end
         req = N'($urandom);
         op_a = {$urandom, $urandom, $urandom, $urandom};
         wait_res(30, c2);
         n_checks++; if (c2 !== 5 || res_valid !== N'(1) << w || res_data !== adder_fn(ea, eb)) begin n_fail++; $display("FAIL rnd_res%0d: got %b/%h at %0d expected client %0d/%h at 5", it, res_valid, res_data, c2, w, adder_fn(ea, eb)); end
         exp_last = w;
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      int c, c2;
      op_a[3*W +: W] = $urandom; op_b[3*W +: W] = $urandom;
      req = 4'b1000;
      wait_gnt(20, c);
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (gnt !== '0 || res_valid !== '0 || add_strt !== 1'b0) begin n_fail++; $display("FAIL t5_pulses: got %b/%b/%b expected all 0", gnt, res_valid, add_strt); end
      n_checks++; if (res_data !== '0 || add_in1 !== '0 || add_in2 !== '0) begin n_fail++; $display("FAIL t5_data: got %h/%h/%h expected all 0", res_data, add_in1, add_in2); end
      @(negedge clk);
      rst = 1'b0;
      exp_last = N - 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++; if (res_valid !== '0) begin n_fail++; $display("FAIL t5_no_result: got %b expected 0", res_valid); end
      end
      req = 4'b1111;
      wait_gnt(20, c);
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t5_restart: got %b expected 0001", gnt); end
      req = '0;
      wait_res(30, c2);
      exp_last = 0;
   endtask

`ifdef FP_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int c, c2;
      adder_dead = 1'b1;
      req = 4'b0010;
      wait_gnt(20, c);
      req = '0;
      wait_res(40, c2);
      n_checks++; if (c2 !== 15 || res_valid !== 4'b0010 || res_data !== 32'h7FC00000) begin n_fail++; $display("FAIL t6_expiry: got %b/%h at %0d expected 0010/7fc00000 at 15", res_valid, res_data, c2); end
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL t6_err: got %b expected 1", timeout_err); end
      @(negedge clk);
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL t6_err_pulse: got %b expected 0", timeout_err); end
      adder_dead = 1'b0;
      exp_last = 1;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_back_to_back();
      test_busy();
      test_spurious_valid();
      test_random();
      test_reset_mid();
`ifdef FP_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
